// File: rtl/uart_pkg.sv
// Shared definitions for the Hangman serial link (uart_tx / uart_rx).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATAOUT = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4
  } uart_state_t;

  localparam int CLKPERBAUD_DEFAULT = 1250;

  localparam int PARITY_MODE_EVEN = 0;
  localparam int PARITY_MODE_ODD  = 1;

  // Parity bit that makes the data plus parity have the selected sense.
  function automatic logic parity_of(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: emits a one-cycle tick on the last cycle of each bit period.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int Clkperbaud = CLKPERBAUD_DEFAULT
) (
  input  logic clk,
  input  logic nRst,
  input  logic clear,
  output logic tick
);

  localparam int CntW = (Clkperbaud > 1) ? $clog2(Clkperbaud) : 1;
  localparam logic [CntW-1:0] TermCnt = CntW'(Clkperbaud - 1);

  logic [CntW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!nRst || clear) begin
      cnt_reg <= '0;
    end else if (cnt_reg == TermCnt) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CntW'(1);
    end
  end

  assign tick = (cnt_reg == TermCnt) && !clear;

endmodule

// File: rtl/uart_tx.sv
// Frame transmitter: start, 8 data bits LSB first, parity, stop; line idles high.
module uart_tx
  import uart_pkg::*;
#(
  parameter int Clkperbaud = CLKPERBAUD_DEFAULT,
  parameter int PARITY_ODD = PARITY_MODE_EVEN
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       tx_ctrl,
  input  logic [7:0] tx_byte,
  output logic       tx_serial,
  output logic       tx_ready,
  output logic       tx_busy
);

  localparam logic OddBit = 1'(PARITY_ODD);

  uart_state_t state_reg, state_next;
  logic [7:0]  shift_reg;
  logic [2:0]  bit_idx_reg;
  logic        parity_reg;
  logic        serial_reg;
  logic        serial_next;
  logic        ready_int;
  logic        baud_clear;
  logic        baud_tick;
  logic        accept;

  uart_baud_tick #(
    .Clkperbaud(Clkperbaud)
  ) u_baud (
    .clk  (clk),
    .nRst (nRst),
    .clear(baud_clear),
    .tick (baud_tick)
  );

  assign accept = (state_reg == IDLE) && tx_ctrl;

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (tx_ctrl) state_next = START;
      START:   if (baud_tick) state_next = DATAOUT;
      DATAOUT: if (baud_tick && bit_idx_reg == 3'd7) state_next = PARITY;
      PARITY:  if (baud_tick) state_next = STOP;
      STOP:    if (baud_tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs derive from registered state only, so inputs never reach a pin combinationally.
  always_comb begin
    serial_next = 1'b1;
    ready_int   = 1'b0;
    baud_clear  = 1'b0;
    case (state_reg)
      IDLE: begin
        ready_int  = 1'b1;
        baud_clear = 1'b1;
      end
      START:   serial_next = 1'b0;
      DATAOUT: serial_next = shift_reg[0];
      PARITY:  serial_next = parity_reg;
      STOP:    serial_next = 1'b1;
      default: serial_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      parity_reg  <= 1'b0;
      serial_reg  <= 1'b1;
    end else begin
      serial_reg <= serial_next;
      if (accept) begin
        shift_reg   <= tx_byte;
        parity_reg  <= parity_of(tx_byte, OddBit);
        bit_idx_reg <= '0;
      end else if (state_reg == DATAOUT && baud_tick) begin
        shift_reg   <= shift_reg >> 1;
        bit_idx_reg <= bit_idx_reg + 3'd1;
      end
    end
  end

  assign tx_serial = serial_reg;
  assign tx_ready  = ready_int;
  assign tx_busy   = ~ready_int;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the wireless Hangman link: accepts one byte per handshake from the game logic and shifts it out on a single line as an 8-E-1 style frame (start, 8 data bits LSB first, parity, stop). It sits directly upstream of `uart_rx`; its `tx_serial` output drives the receiver's `rx_serial`, and its frame format matches the receiver's IDLE/START/DATAIN/PARITY/STOP sequence bit for bit.

## Interface
- `Clkperbaud`, 1250: clock cycles per bit period; must be ≥ 2.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd parity.
- `clk`  in  1  system clock.
- `nRst`  in  1  reset; one clock; reset is synchronous and active-low.
- `tx_ctrl`  in  1  send request; sampled only while `tx_ready` = 1.
- `tx_byte`  in  8  data to send; captured on the accepting edge.
- `tx_serial`  out  1  serial line; idles high.
- `tx_ready`  out  1  high when idle and able to accept a byte.
- `tx_busy`  out  1  high from the accepting edge through the last stop-bit cycle; always the inverse of `tx_ready`.

## Operation
- States: IDLE, START, DATAOUT, PARITY, STOP.
- IDLE: `tx_serial` = 1, `tx_ready` = 1. On an edge with `tx_ctrl` = 1:
  - latch `tx_byte` into the shift register;
  - latch the parity bit, `^tx_byte ^ PARITY_ODD`;
  - clear the baud counter and bit index;
  - go to START.
- START: `tx_serial` = 0 for `Clkperbaud` cycles, then DATAOUT.
- DATAOUT: `tx_serial` = shift[0] for `Clkperbaud` cycles per bit. At the end of each bit period, shift right and increment the bit index (3 bits). After bit index 7 finishes, go to PARITY.
- PARITY: `tx_serial` = parity bit for `Clkperbaud` cycles, then STOP.
- STOP: `tx_serial` = 1 for `Clkperbaud` cycles, then IDLE.
- `tx_ctrl` is ignored outside IDLE. `tx_byte` changes after acceptance do not affect the frame in flight.
- Baud counter:
  - width `$clog2(Clkperbaud)`;
  - counts 0 to `Clkperbaud`-1;
  - the terminal count advances the state or bit and wraps the counter to 0.
- `tx_serial` is registered and glitch-free; it changes only on bit boundaries.

## Timing
- Reset (`nRst` = 0 at an edge), whether idle or mid-frame, sets on that edge:
  - state = IDLE, `tx_serial` = 1, `tx_ready` = 1, `tx_busy` = 0;
  - counters = 0, shift register = 0, parity = 0.
- A request present during reset is not accepted.
- Accepting edge k produces `tx_serial` = 0 from edge k+1.
- Each bit occupies exactly `Clkperbaud` cycles. The frame is 11 × `Clkperbaud` cycles, ending at edge k+11·`Clkperbaud`, when state returns to IDLE and `tx_ready` rises.
- Back-to-back: if `tx_ctrl` is held high, the next byte is accepted on the first IDLE cycle, so the next start bit begins at edge k+11·`Clkperbaud`+2. The line gets at least one extra idle-high cycle between frames.
- `tx_ctrl` asserted on the same edge that STOP ends is not accepted; it is sampled again on the following IDLE edge.
- No combinational path from inputs to outputs.

## Structure
- Shared package `uart_pkg`, also used by `uart_rx`, holds:
  - the state enum `uart_state_t` (3-bit encoding);
  - `CLKPERBAUD_DEFAULT` = 1250;
  - parity-mode constants.
- One sub-module, `uart_baud_tick`:
  - parameterised by `Clkperbaud`, with a synchronous clear input;
  - emits a one-cycle `tick` at terminal count.
- `uart_tx` holds the FSM, shift register, bit index and parity register.

## Test plan
- Reset mid-frame: assert `nRst` = 0 during DATAOUT of 8'hAB. Required on the next edge: `tx_serial` = 1, `tx_ready` = 1; the line then stays high with `tx_ctrl` = 0.
- 8'hAB, even parity, `Clkperbaud` = 16: pulse `tx_ctrl` one cycle. Line samples at each bit centre must be 0, 1,1,0,1,0,1,0,1, 1 (parity), 1 (stop). `tx_ready` rises exactly 176 cycles after acceptance.
- 8'h00 with `PARITY_ODD` = 1: required parity bit = 1. 8'h00 with `PARITY_ODD` = 0: required parity bit = 0.
- Ignore while busy: change `tx_byte` to 8'h55 and pulse `tx_ctrl` mid-frame of 8'hAB. The frame stays 8'hAB; no second frame follows.
- Back-to-back: hold `tx_ctrl` = 1 with 8'h41 then 8'h5A. Required: two frames, with the second start bit falling exactly 11·`Clkperbaud`+2 cycles after the first acceptance.
- Loopback, `Clkperbaud` = 1250: connect `tx_serial` to `uart_rx` and send 8'h48. Required: the receiver reports `rx_byte` = 8'h48 and neither parity error LED lights.
